// File: rtl/ram_1r1w.sv
// Simple-dual-port word memory: one write port, one read port, single clock.
// Registered read output with write-first bypass on same-address collisions.
module ram_1r1w #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 14,
  parameter int DEPTH     = 2**ADDR_W,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic              ren,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // One extra bit so DEPTH == 2**ADDR_W is representable in the range check.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic              wr_ok_s;
  logic              rd_in_range_s;

  // Power-up contents cleared to zero.
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
    end
  end

  // Write qualification and next read data, including write-first bypass.
  always_comb begin
    wr_ok_s       = wen && !rst && ({1'b0, waddr} < DEPTH_L);
    rd_in_range_s = ({1'b0, raddr} < DEPTH_L);
    rdata_d       = rdata_q;
    if (ren) begin
      if (!rd_in_range_s) begin
        rdata_d = '0;
      end else if (wr_ok_s && (waddr == raddr)) begin
        rdata_d = wdata;
      end else begin
        rdata_d = mem[raddr];
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Storage array; never touched by reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem[waddr] <= wdata;
    end
  end

  // Read data register, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_ram_1r1w.sv
// Self-checking bench for ram_1r1w: directed scenarios plus randomized traffic
// compared against an array-based reference memory.
module tb_ram_1r1w;

  localparam int DW    = 32;
  localparam int AW    = 14;
  localparam int DEPTH = 16384;

  logic          clk = 1'b0;
  logic          rst;
  logic          wen, ren;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] wdata, rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] ref_rdata;

  always #5 clk = ~clk;

  ram_1r1w #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst), .wen(wen), .ren(ren),
    .waddr(waddr), .raddr(raddr), .wdata(wdata), .rdata(rdata)
  );

  // Advance one rising edge and update the reference model from the inputs seen there.
  task automatic tick();
    logic [DW-1:0] nxt;
    @(posedge clk);
    nxt = ref_rdata;
    if (rst) begin
      nxt = '0;
    end else begin
      if (ren) nxt = (wen && waddr == raddr) ? wdata : ref_mem[raddr];
      if (wen) ref_mem[waddr] = wdata;
    end
    ref_rdata = nxt;
    #1;
  endtask

  task automatic idle();
    wen = 1'b0; ren = 1'b0; waddr = '0; raddr = '0; wdata = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wen = 1'b1; ren = 1'b0; waddr = a; wdata = d;
    tick();
    wen = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    wen = 1'b0; ren = 1'b1; raddr = a;
    tick();
    ren = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    tick(); tick();
    n_cmp++;
    if (rdata !== 32'h0) begin
      n_bad++; $display("FAIL reset_value: got %h want %h", rdata, 32'h0);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    do_read(14'd0);
    n_cmp++;
    if (rdata !== 32'h0) begin
      n_bad++; $display("FAIL basic_read_zero: got %h want %h", rdata, 32'h0);
    end
    do_write(14'd1, 32'd256);
    do_read(14'd1);
    n_cmp++;
    if (rdata !== 32'd256) begin
      n_bad++; $display("FAIL basic_read_back: got %h want %h", rdata, 32'd256);
    end
  endtask

  task automatic test_hold();
    do_write(14'd5, 32'hDEADBEEF);
    do_read(14'd5);
    n_cmp++;
    if (rdata !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL hold_read: got %h want %h", rdata, 32'hDEADBEEF);
    end
    ren = 1'b0; raddr = 14'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (rdata !== 32'hDEADBEEF) begin
        n_bad++; $display("FAIL hold_cycle%0d: got %h want %h", i, rdata, 32'hDEADBEEF);
      end
    end
  endtask

  task automatic test_collision();
    do_write(14'd7, 32'h11111111);
    wen = 1'b1; ren = 1'b1; waddr = 14'd7; raddr = 14'd7; wdata = 32'h22222222;
    tick();
    n_cmp++;
    if (rdata !== 32'h22222222) begin
      n_bad++; $display("FAIL collision_bypass: got %h want %h", rdata, 32'h22222222);
    end
    do_read(14'd7);
    n_cmp++;
    if (rdata !== 32'h22222222) begin
      n_bad++; $display("FAIL collision_stored: got %h want %h", rdata, 32'h22222222);
    end
  endtask

  task automatic test_async_reset();
    do_write(14'd9, 32'h12345678);
    do_read(14'd9);
    n_cmp++;
    if (rdata !== 32'h12345678) begin
      n_bad++; $display("FAIL areset_pre: got %h want %h", rdata, 32'h12345678);
    end
    #2;
    rst = 1'b1; ref_rdata = '0;
    #1;
    n_cmp++;
    if (rdata !== 32'h0) begin
      n_bad++; $display("FAIL areset_immediate: got %h want %h", rdata, 32'h0);
    end
    // A write attempted during reset must be dropped.
    wen = 1'b1; waddr = 14'd9; wdata = 32'hFFFFFFFF; ren = 1'b1; raddr = 14'd9;
    tick();
    n_cmp++;
    if (rdata !== 32'h0) begin
      n_bad++; $display("FAIL areset_held: got %h want %h", rdata, 32'h0);
    end
    rst = 1'b0; wen = 1'b0;
    do_read(14'd9);
    n_cmp++;
    if (rdata !== 32'h12345678) begin
      n_bad++; $display("FAIL areset_contents: got %h want %h", rdata, 32'h12345678);
    end
  endtask

  task automatic test_boundary();
    do_write(14'd0, 32'hA5A5A5A5);
    do_write(14'd16383, 32'h5A5A5A5A);
    do_read(14'd0);
    n_cmp++;
    if (rdata !== 32'hA5A5A5A5) begin
      n_bad++; $display("FAIL boundary_low: got %h want %h", rdata, 32'hA5A5A5A5);
    end
    do_read(14'd16383);
    n_cmp++;
    if (rdata !== 32'h5A5A5A5A) begin
      n_bad++; $display("FAIL boundary_high: got %h want %h", rdata, 32'h5A5A5A5A);
    end
    do_read(14'd0);
    n_cmp++;
    if (rdata !== 32'hA5A5A5A5) begin
      n_bad++; $display("FAIL boundary_alias: got %h want %h", rdata, 32'hA5A5A5A5);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp;
    for (int i = 0; i < 16; i++) begin
      wen = 1'b1; ren = 1'b0; waddr = AW'(i); wdata = DW'(i * 3);
      tick();
    end
    wen = 1'b0; ren = 1'b1;
    for (int i = 0; i < 16; i++) begin
      raddr = AW'(i);
      tick();
      exp = DW'(i * 3);
      n_cmp++;
      if (rdata !== exp) begin
        n_bad++; $display("FAIL stream_addr%0d: got %h want %h", i, rdata, exp);
      end
    end
    ren = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      wen   = 1'($urandom_range(0, 1));
      ren   = 1'($urandom_range(0, 1));
      waddr = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      raddr = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, 15));
      wdata = DW'($urandom);
      rst   = ($urandom_range(0, 49) == 0);
      if (rst) ref_rdata = '0;
      tick();
      n_cmp++;
      if (rdata !== ref_rdata) begin
        n_bad++; $display("FAIL random_cycle%0d: got %h want %h", i, rdata, ref_rdata);
      end
      rst = 1'b0;
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_rdata = '0;
    rst = 1'b1;
    idle();
    test_reset();
    test_basic();
    test_hold();
    test_collision();
    test_async_reset();
    test_boundary();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
